epc_slave: RTL and testbench

EPC_SLAVE -- requirements
Module: epc_slave

---
 rtl/epc_pkg.sv | 20 ++
 rtl/epc_slave.sv | 143 ++++++++++++++
 tb/tb_epc_slave.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/epc_pkg.sv
// rtl/epc_pkg.sv - shared types and constants for the EPC slave bridge
package epc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_RDY,
        ST_HOLD
    } epc_state_t;

    localparam int          EPC_TIMEOUT  = 8;
    localparam logic [31:0] EPC_ERR_DATA = 32'hDEADBEEF;
    localparam int          EPC_WIN_BITS = 16;

    function automatic logic [7:0] epc_sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/epc_slave.sv
// rtl/epc_slave.sv - EPC bus slave bridging to a single-cycle-strobe register back end
module epc_slave
    import epc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        epc_cs_n,
    input  logic        epc_ads,
    input  logic        epc_rnw,
    input  logic [0:31] epc_addr,
    input  logic [0:3]  epc_be,
    input  logic [0:31] epc_wdata,
    output logic [0:31] epc_rdata,
    output logic        epc_rdy,
    output logic [13:0] reg_addr,
    output logic [3:0]  reg_be,
    output logic [31:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    output logic [7:0]  err_cnt
);

    epc_state_t  r_state;
    logic        r_rnw;
    logic [3:0]  r_tmo_cnt;
    logic [31:0] r_epc_rdata;
    logic        r_epc_rdy;
    logic [13:0] r_reg_addr;
    logic [3:0]  r_reg_be;
    logic [31:0] r_reg_wdata;
    logic        r_reg_wr;
    logic        r_reg_rd;
    logic [7:0]  r_err_cnt;

    logic w_start;
    logic w_in_window;
    logic w_unused_addr;

    assign w_start       = (r_state == ST_IDLE) && !epc_cs_n && epc_ads;
    assign w_in_window   = (epc_addr[0:EPC_WIN_BITS-1] == '0);
    // The low two address bits select a byte within the word and are not decoded.
    assign w_unused_addr = ^epc_addr[30:31];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rnw       <= 1'b0;
            r_tmo_cnt   <= 4'd0;
            r_epc_rdata <= 32'd0;
            r_epc_rdy   <= 1'b0;
            r_reg_addr  <= 14'd0;
            r_reg_be    <= 4'd0;
            r_reg_wdata <= 32'd0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_reg_wr  <= 1'b0;
            r_reg_rd  <= 1'b0;
            r_epc_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_reg_addr  <= epc_addr[16:29];
                        r_reg_be    <= epc_be;
                        r_reg_wdata <= epc_wdata;
                        r_rnw       <= epc_rnw;
                        if (w_in_window) begin
                            r_reg_wr <= !epc_rnw;
                            r_reg_rd <= epc_rnw;
                            r_state  <= ST_STROBE;
                        end else begin
                            if (epc_rnw) begin
                                r_epc_rdata <= EPC_ERR_DATA;
                            end
                            r_err_cnt <= epc_sat_inc(r_err_cnt);
                            r_epc_rdy <= 1'b1;
                            r_state   <= ST_RDY;
                        end
                    end
                end
                ST_STROBE: begin
                    if (epc_cs_n) begin
                        r_state <= ST_IDLE;
                    end else if (reg_ack) begin
                        if (r_rnw) begin
                            r_epc_rdata <= reg_rdata;
                        end
                        r_epc_rdy <= 1'b1;
                        r_state   <= ST_RDY;
                    end else begin
                        r_tmo_cnt <= 4'd0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Abort wins over a coincident ack so a withdrawn transfer never completes.
                    if (epc_cs_n) begin
                        r_state <= ST_IDLE;
                    end else if (reg_ack) begin
                        if (r_rnw) begin
                            r_epc_rdata <= reg_rdata;
                        end
                        r_epc_rdy <= 1'b1;
                        r_state   <= ST_RDY;
                    end else if (r_tmo_cnt == 4'(EPC_TIMEOUT - 1)) begin
                        if (r_rnw) begin
                            r_epc_rdata <= EPC_ERR_DATA;
                        end
                        r_err_cnt <= epc_sat_inc(r_err_cnt);
                        r_epc_rdy <= 1'b1;
                        r_state   <= ST_RDY;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 4'd1;
                    end
                end
                ST_RDY: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (epc_cs_n) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign epc_rdata = r_epc_rdata;
    assign epc_rdy   = r_epc_rdy;
    assign reg_addr  = r_reg_addr;
    assign reg_be    = r_reg_be;
    assign reg_wdata = r_reg_wdata;
    assign reg_wr    = r_reg_wr;
    assign reg_rd    = r_reg_rd;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_epc_slave.sv
// tb/tb_epc_slave.sv - directed self-checking bench for epc_slave
module tb_epc_slave;

    logic        clk;
    logic        rst_n;
    logic        epc_cs_n;
    logic        epc_ads;
    logic        epc_rnw;
    logic [0:31] epc_addr;
    logic [0:3]  epc_be;
    logic [0:31] epc_wdata;
    logic [0:31] epc_rdata;
    logic        epc_rdy;
    logic [13:0] reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic [7:0]  err_cnt;

    int n_pass;
    int n_total;
    int n_wr;
    int n_rd;
    int n_rdy;

    epc_slave dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .epc_cs_n  (epc_cs_n),
        .epc_ads   (epc_ads),
        .epc_rnw   (epc_rnw),
        .epc_addr  (epc_addr),
        .epc_be    (epc_be),
        .epc_wdata (epc_wdata),
        .epc_rdata (epc_rdata),
        .epc_rdy   (epc_rdy),
        .reg_addr  (reg_addr),
        .reg_be    (reg_be),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr)  n_wr++;
        if (reg_rd)  n_rd++;
        if (epc_rdy) n_rdy++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic start(input logic rnw, input logic [31:0] addr, input logic [31:0] wd);
        epc_cs_n  = 1'b0;
        epc_ads   = 1'b1;
        epc_rnw   = rnw;
        epc_addr  = addr;
        epc_be    = 4'hF;
        epc_wdata = wd;
        tick();
        epc_ads = 1'b0;
    endtask

    task automatic release_cs();
        epc_cs_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int  wr0;
        int  rd0;
        int  rdy0;
        logic early;
        n_pass = 0; n_total = 0; n_wr = 0; n_rd = 0; n_rdy = 0;
        rst_n = 1'b0; epc_cs_n = 1'b1; epc_ads = 1'b0; epc_rnw = 1'b0;
        epc_addr = '0; epc_be = '0; epc_wdata = '0; reg_rdata = '0; reg_ack = 1'b0;
        tick(); tick();
        chk("rst_rdy", epc_rdy, 0);
        chk("rst_rdata", epc_rdata, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_strobes", {reg_wr, reg_rd}, 0);
        rst_n = 1'b1;
        tick();

        // Write 0x100, ack one cycle after the strobe
        wr0 = n_wr; rdy0 = n_rdy;
        start(1'b0, 32'h0000_0100, 32'h1234_5678);
        chk("wr_strobe", reg_wr, 1);
        chk("wr_addr", reg_addr, 14'h040);
        chk("wr_wdata", reg_wdata, 32'h1234_5678);
        chk("wr_be", reg_be, 4'hF);
        tick();
        chk("wr_strobe_gone", reg_wr, 0);
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        chk("wr_rdy", epc_rdy, 1);
        tick();
        chk("wr_rdy_one_cycle", epc_rdy, 0);
        release_cs();
        chk("wr_pulses", n_wr - wr0, 1);
        chk("wr_rdy_pulses", n_rdy - rdy0, 1);
        chk("wr_err", err_cnt, 0);
        chk("wr_rdata_kept", epc_rdata, 0);

        // Read 0x314, ack in the strobe cycle
        rd0 = n_rd;
        start(1'b1, 32'h0000_0314, 32'h0);
        chk("rd_strobe", reg_rd, 1);
        chk("rd_addr", reg_addr, 14'h0C5);
        reg_ack = 1'b1; reg_rdata = 32'hCAFE_0001;
        tick();
        reg_ack = 1'b0; reg_rdata = 32'h0;
        chk("rd_rdy_T2", epc_rdy, 1);
        chk("rd_rdata", epc_rdata, 32'hCAFE_0001);
        release_cs();
        chk("rd_pulses", n_rd - rd0, 1);
        chk("rd_rdata_hold", epc_rdata, 32'hCAFE_0001);

        // Out-of-window read
        rd0 = n_rd;
        start(1'b1, 32'hA5A5_A5A5, 32'h0);
        chk("oow_rdy_T1", epc_rdy, 1);
        chk("oow_rdata", epc_rdata, 32'hDEAD_BEEF);
        chk("oow_err", err_cnt, 1);
        release_cs();
        chk("oow_no_rd", n_rd - rd0, 0);

        // Timeout read: rdy must appear at T+10 and not before
        start(1'b1, 32'h0000_0004, 32'h0);
        early = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (epc_rdy) early = 1'b1;
            tick();
        end
        chk("tmo_no_early_rdy", early, 0);
        chk("tmo_rdy_T10", epc_rdy, 1);
        chk("tmo_rdata", epc_rdata, 32'hDEAD_BEEF);
        chk("tmo_err", err_cnt, 2);
        release_cs();

        // Abort in WAIT, then a late ack
        rdy0 = n_rdy;
        start(1'b1, 32'h0000_0008, 32'h0);
        tick();
        epc_cs_n = 1'b1;
        tick();
        reg_ack = 1'b1; reg_rdata = 32'h1111_1111;
        tick();
        reg_ack = 1'b0;
        tick(); tick();
        chk("abort_no_rdy", n_rdy - rdy0, 0);
        chk("abort_rdata", epc_rdata, 32'hDEAD_BEEF);
        chk("abort_err", err_cnt, 2);
        wr0 = n_wr;
        start(1'b0, 32'h0000_0020, 32'h0000_000A);
        chk("post_abort_wr", reg_wr, 1);
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        chk("post_abort_rdy", epc_rdy, 1);
        release_cs();
        chk("post_abort_pulses", n_wr - wr0, 1);

        // 300 out-of-window writes saturate err_cnt
        for (int i = 0; i < 300; i++) begin
            start(1'b0, 32'hFFFF_0000, 32'h5555_5555);
            tick();
            epc_cs_n = 1'b1;
            tick();
        end
        chk("sat_err", err_cnt, 8'hFF);
        chk("sat_rdata_kept", epc_rdata, 32'hDEAD_BEEF);

        // Reset during WAIT
        rdy0 = n_rdy;
        start(1'b1, 32'h0000_0000, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_rdy", epc_rdy, 0);
        chk("mid_rst_strobes", {reg_wr, reg_rd}, 0);
        chk("mid_rst_rdata", epc_rdata, 0);
        chk("mid_rst_addr", reg_addr, 0);
        chk("mid_rst_be_wdata", {reg_be, reg_wdata}, 0);
        chk("mid_rst_err", err_cnt, 0);
        rst_n = 1'b1;
        epc_cs_n = 1'b1;
        tick(); tick();
        chk("mid_rst_no_rdy", n_rdy - rdy0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
